// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO pair: fixed-latency multiply and
// accumulate, a restoring divider producing one quotient bit per cycle, MTHI/MTLO writes and flush.
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_LOAD = 3'd2,
        S_DIV_ITER = 3'd3,
        S_DIV_FIX  = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [2:0]           op_r, op_s;
    logic [WIDTH-1:0]     a_r, a_s;
    logic [WIDTH-1:0]     b_r, b_s;
    logic [WIDTH-1:0]     rem_r, rem_s;
    logic [WIDTH-1:0]     quot_r, quot_s;
    logic                 div0_r, div0_s;
    logic                 q_neg_r, q_neg_s;
    logic                 r_neg_r, r_neg_s;
    logic [WIDTH-1:0]     hi_r, hi_s;
    logic [WIDTH-1:0]     lo_r, lo_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;

    logic [2*WIDTH-1:0]   a_ext_s, b_ext_s, prod_s, mul_res_s;
    logic [WIDTH:0]       shift_s, diff_s;

    // Datapath helpers: sign-aware product, accumulate result and one restoring step.
    always_comb begin
        if (op_r[0]) begin
            a_ext_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
            b_ext_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
        end else begin
            a_ext_s = {{WIDTH{1'b0}}, a_r};
            b_ext_s = {{WIDTH{1'b0}}, b_r};
        end
        prod_s = a_ext_s * b_ext_s;
        if (!op_r[2]) begin
            mul_res_s = prod_s;
        end else if (op_r[1]) begin
            mul_res_s = {hi_r, lo_r} - prod_s;
        end else begin
            mul_res_s = {hi_r, lo_r} + prod_s;
        end
        shift_s = {rem_r, quot_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, b_r};
    end

    // Next-state and next-register computation; flush outranks everything but reset.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        a_s     = a_r;
        b_s     = b_r;
        rem_s   = rem_r;
        quot_s  = quot_r;
        div0_s  = div0_r;
        q_neg_s = q_neg_r;
        r_neg_s = r_neg_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        if (flush && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_s   = op;
                        a_s    = in1;
                        b_s    = in2;
                        div0_s = (in2 == {WIDTH{1'b0}});
                        busy_s = 1'b1;
                        if (!op[2] && op[1]) begin
                            state_s = S_DIV_LOAD;
                        end else begin
                            state_s = S_MUL;
                            cnt_s   = CNT_W'(MUL_LAT);
                        end
                    end else if (!start) begin
                        if (hi_we) begin
                            hi_s = in1;
                        end else begin
                            hi_s = hi_r;
                        end
                        if (lo_we) begin
                            lo_s = in1;
                        end else begin
                            lo_s = lo_r;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (cnt_r == CNT_W'(1)) begin
                        {hi_s, lo_s} = mul_res_s;
                        state_s      = S_IDLE;
                        busy_s       = 1'b0;
                        done_s       = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                S_DIV_LOAD: begin
                    // Signed divide runs on magnitudes; signs are reapplied in the fixup cycle.
                    if (op_r[0]) begin
                        quot_s  = a_r[WIDTH-1] ? negate(a_r) : a_r;
                        b_s     = b_r[WIDTH-1] ? negate(b_r) : b_r;
                        q_neg_s = a_r[WIDTH-1] ^ b_r[WIDTH-1];
                        r_neg_s = a_r[WIDTH-1];
                    end else begin
                        quot_s  = a_r;
                        b_s     = b_r;
                        q_neg_s = 1'b0;
                        r_neg_s = 1'b0;
                    end
                    rem_s   = {WIDTH{1'b0}};
                    cnt_s   = CNT_W'(WIDTH);
                    state_s = S_DIV_ITER;
                end
                S_DIV_ITER: begin
                    if (!diff_s[WIDTH]) begin
                        rem_s  = diff_s[WIDTH-1:0];
                        quot_s = {quot_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_s  = shift_s[WIDTH-1:0];
                        quot_s = {quot_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_s = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_s = S_DIV_FIX;
                    end else begin
                        state_s = S_DIV_ITER;
                    end
                end
                S_DIV_FIX: begin
                    if (!div0_r) begin
                        lo_s = q_neg_r ? negate(quot_r) : quot_r;
                        hi_s = r_neg_r ? negate(rem_r) : rem_r;
                    end else begin
                        lo_s = lo_r;
                        hi_s = hi_r;
                    end
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end
                default: begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'd0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quot_r  <= {WIDTH{1'b0}};
            div0_r  <= 1'b0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            a_r     <= a_s;
            b_r     <= b_s;
            rem_r   <= rem_s;
            quot_r  <= quot_s;
            div0_r  <= div0_s;
            q_neg_r <= q_neg_s;
            r_neg_r <= r_neg_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: 32-bit instance for multiply/divide/flush/reset scenarios,
// plus an 8-bit instance for the narrow divide case.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2, hi, lo;
    logic [2:0]  op;
    logic        start, hi_we, lo_we, flush, busy, done;
    logic [7:0]  in1_8, in2_8, hi_8, lo_8;
    logic [2:0]  op_8;
    logic        start_8, hi_we_8, lo_we_8, flush_8, busy_8, done_8;

    int n_vec = 0;
    int n_err = 0;
    int bc, dc;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) u32 (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .start(start), .op(op),
        .hi_we(hi_we), .lo_we(lo_we), .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    mdu_iter #(.WIDTH(8), .MUL_LAT(5)) u8 (
        .clk(clk), .reset(reset), .in1(in1_8), .in2(in2_8), .start(start_8), .op(op_8),
        .hi_we(hi_we_8), .lo_we(lo_we_8), .flush(flush_8), .hi(hi_8), .lo(lo_8), .busy(busy_8), .done(done_8)
    );

    // Launch one op on the 32-bit unit and report busy length and done pulses seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_cnt);
        @(negedge clk); in1 = a; in2 = b; op = o; start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_cycles = 0; done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) begin
                busy_cycles++;
            end else begin
                if (done) done_cnt++;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk); in1 = h; hi_we = 1'b1;
        @(negedge clk); hi_we = 1'b0; in1 = l; lo_we = 1'b1;
        @(negedge clk); lo_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (hi !== 32'h0)   begin n_err++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        n_vec++; if (lo !== 32'h0)   begin n_err++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_mult();
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc, dc);
        n_vec++; if (bc !== 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", bc); end
        n_vec++; if (dc !== 1) begin n_err++; $display("FAIL mult_done: got %0d want 1", dc); end
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        n_vec++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_vec++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_div();
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc, dc);
        n_vec++; if (bc !== 34) begin n_err++; $display("FAIL div_busy: got %0d want 34", bc); end
        n_vec++; if (dc !== 1)  begin n_err++; $display("FAIL div_done: got %0d want 1", dc); end
        n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(3'd2, 32'd100, 32'd7, bc, dc);
        n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %0d want 14", lo); end
        n_vec++; if (hi !== 32'd2)  begin n_err++; $display("FAIL divu_hi: got %0d want 2", hi); end
    endtask

    task automatic test_mac();
        write_hilo(32'h0, 32'hFFFF_FFFF);
        n_vec++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL mtlo: got %h want 00000000ffffffff", {hi, lo}); end
        run_op(3'd4, 32'd1, 32'd1, bc, dc);
        n_vec++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL maddu: got %h want 0000000100000000", {hi, lo}); end
        run_op(3'd7, 32'd1, 32'd1, bc, dc);
        n_vec++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL msub: got %h want 00000000ffffffff", {hi, lo}); end
    endtask

    task automatic test_div_edge();
        write_hilo(32'h11, 32'h22);
        run_op(3'd3, 32'd5, 32'd0, bc, dc);
        n_vec++; if (bc !== 34) begin n_err++; $display("FAIL div0_busy: got %0d want 34", bc); end
        n_vec++; if (dc !== 1)  begin n_err++; $display("FAIL div0_done: got %0d want 1", dc); end
        n_vec++; if ({hi, lo} !== 64'h0000_0011_0000_0022) begin n_err++; $display("FAIL div0_hilo: got %h want 0000001100000022", {hi, lo}); end
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        n_vec++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divmin_lo: got %h want 80000000", lo); end
        n_vec++; if (hi !== 32'h0)         begin n_err++; $display("FAIL divmin_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_flush();
        write_hilo(32'hAA, 32'hBB);
        @(negedge clk); in1 = 32'd100; in2 = 32'd7; op = 3'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
        dc = 0;
        repeat (40) begin @(negedge clk); if (done) dc++; end
        n_vec++; if (dc !== 0) begin n_err++; $display("FAIL flush_done: got %0d want 0", dc); end
        n_vec++; if ({hi, lo} !== 64'h0000_00AA_0000_00BB) begin n_err++; $display("FAIL flush_hilo: got %h want 000000aa000000bb", {hi, lo}); end
    endtask

    task automatic test_start_while_busy();
        @(negedge clk); in1 = 32'd2; in2 = 32'd3; op = 3'd0; start = 1'b1;
        @(negedge clk); in1 = 32'h55; lo_we = 1'b1;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            bc++;
            @(negedge clk);
        end
        start = 1'b0; lo_we = 1'b0;
        n_vec++; if (bc !== 5) begin n_err++; $display("FAIL hold_busy: got %0d want 5", bc); end
        n_vec++; if (lo !== 32'd6) begin n_err++; $display("FAIL hold_lo: got %h want 00000006", lo); end
        // the start still high in the done cycle is legitimately accepted; let it finish
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); in1 = 32'd3; in2 = 32'd4; op = 3'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done); end
        n_vec++; if (lo !== 32'd12) begin n_err++; $display("FAIL b2b_lo1: got %0d want 12", lo); end
        in1 = 32'd5; in2 = 32'd6; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        n_vec++; if (lo !== 32'd30) begin n_err++; $display("FAIL b2b_lo2: got %0d want 30", lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); in1 = 32'd9; in2 = 32'd9; op = 3'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        n_vec++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL rstmid_hilo: got %h want 0", {hi, lo}); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        dc = 0;
        repeat (8) begin @(negedge clk); if (done) dc++; end
        n_vec++; if (dc !== 0) begin n_err++; $display("FAIL rstmid_done: got %0d want 0", dc); end
    endtask

    task automatic test_width8();
        @(negedge clk); in1_8 = 8'd200; in2_8 = 8'd9; op_8 = 3'd2; start_8 = 1'b1;
        @(negedge clk); start_8 = 1'b0;
        bc = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy_8) break;
            bc++;
            @(negedge clk);
        end
        n_vec++; if (bc !== 10) begin n_err++; $display("FAIL w8_busy: got %0d want 10", bc); end
        n_vec++; if (lo_8 !== 8'd22) begin n_err++; $display("FAIL w8_lo: got %0d want 22", lo_8); end
        n_vec++; if (hi_8 !== 8'd2)  begin n_err++; $display("FAIL w8_hi: got %0d want 2", hi_8); end
    endtask

    initial begin
        reset = 1'b1; in1 = 32'h0; in2 = 32'h0; op = 3'd0; start = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
        in1_8 = 8'h0; in2_8 = 8'h0; op_8 = 3'd0; start_8 = 1'b0;
        hi_we_8 = 1'b0; lo_we_8 = 1'b0; flush_8 = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mac();
        test_div_edge();
        test_flush();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage. It owns the HI/LO register pair and supports MULT/MULTU, accumulate variants (MADD/MADDU/MSUB/MSUBU) and DIV/DIVU. Division uses an iterative restoring divider producing one quotient bit per cycle. It also accepts MTHI/MTLO writes and a flush that aborts an in-flight operation without touching HI/LO.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO
MUL_LAT, 5, busy cycles for any multiply-class op (must be >= 1)
DIV_LAT, derived = WIDTH+2, busy cycles for divide (1 load + WIDTH iterations + 1 sign fixup); not overridable

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  synchronous, active-high
in1  in  WIDTH  operand A; also data for HI/LO writes
in2  in  WIDTH  operand B
start  in  1  launch op selected by op
op  in  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB
hi_we  in  1  HI <= in1
lo_we  in  1  LO <= in1
flush  in  1  abort in-flight op
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO
busy  out  1  operation in flight
done  out  1  one-cycle pulse, first cycle hi/lo show the op's result

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, internal counter/remainder/quotient cleared. Reset mid-operation discards it.
- FSM: IDLE, MUL, DIV_LOAD, DIV_ITER, DIV_FIX.
- IDLE + start (flush=0): operands and op latched. Multiply-class ops go to MUL with counter=MUL_LAT. Div ops go to DIV_LOAD.
- busy is high for exactly MUL_LAT (mul) or DIV_LAT (div) cycles, starting the cycle after the start edge.
- On the edge ending the last busy cycle, hi/lo update. In the following cycle busy=0 and done=1.
- MUL: full 2*WIDTH product computed, signed for odd op codes. Accumulate ops apply {HI,LO} +/- product modulo 2^(2*WIDTH), using HI/LO as sampled at result commit (not at start). MULTU/MULT overwrite {HI,LO}.
- DIV_LOAD: for DIV, take absolute values and record quotient/remainder signs. DIVU uses operands as-is.
- DIV_ITER: WIDTH cycles, one restoring step each, MSB first.
- DIV_FIX: negate quotient if the operand signs differ; remainder takes the dividend's sign. Then LO=quotient, HI=remainder.
- Divide by zero: full DIV_LAT busy period, done still pulses, hi/lo unchanged.
- DIV of MIN by -1: LO=MIN (wraps), HI=0.
- start while busy: ignored, no queuing.
- start at the same edge the FSM returns to IDLE (busy=0 that cycle): accepted.
- hi_we/lo_we: honoured only when busy=0 and start=0; both may assert together. Ignored while busy. start has priority (same-cycle writes are dropped).
- flush: highest priority after reset. From any state: FSM->IDLE, busy=0 next cycle, no done, hi/lo unchanged. A start in the same cycle as flush is ignored. flush in IDLE has no effect.
- hi/lo outputs come directly from registers, with no bypass of in-flight results.

Test Plan:
- MULT in1=0xFFFFFFFE (-2), in2=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- DIV in1=-7, in2=2 -> busy 34 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- hi=0, lo=0xFFFFFFFF; MADDU 1*1 -> hi=1, lo=0. Then MSUB 1*1 -> hi=0, lo=0xFFFFFFFF.
- DIV by 0 with hi=0x11, lo=0x22 -> 34 busy cycles, done pulses, hi/lo stay 0x11/0x22. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- flush in busy cycle 10 of a DIV -> busy=0 next cycle, no done, hi/lo unchanged. start held during busy -> no restart. lo_we during busy -> ignored.
- reset asserted mid-MUL -> hi=lo=0, busy=0 next cycle. WIDTH=8 instance: DIVU 200/9 -> lo=22, hi=2, busy 10 cycles.
